// File: rtl/note_duration_recorder.sv
// Measures note and rest lengths from the debounced key code in whole beat ticks
// and queues quantised (pitch, duration) entries in a first-word-fall-through buffer.
module note_duration_recorder #(
    parameter int unsigned TICK_CYCLES = 524288,
    parameter int unsigned DEPTH       = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [4:0]               key_code,
    input  logic                     rd_en,
    output logic                     rd_valid,
    output logic [4:0]               rd_pitch,
    output logic [2:0]               rd_dur,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     overflow
);

    localparam int unsigned PITCH_W = 5;
    localparam int unsigned DUR_W   = 3;
    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned PRESC_W = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_CYCLES - 1);
    localparam logic [DUR_W-1:0]   DUR_MAX    = DUR_W'(7);
    localparam logic [CNT_W-1:0]   CNT_FULL   = CNT_W'(DEPTH);

    typedef struct packed {
        logic [PITCH_W-1:0] pitch;
        logic [DUR_W-1:0]   dur;
    } entry_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_REST = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [PITCH_W-1:0]   key_q, key_prev_q;
    logic [PITCH_W-1:0]   cur_pitch_q, cur_pitch_d;
    logic [PRESC_W-1:0]   presc_q, presc_d;
    logic [DUR_W-1:0]     dur_q, dur_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 overflow_q, overflow_d;
    entry_t               mem_q [DEPTH];

    logic                 event_c;
    logic                 counting_c;
    logic                 tick_c;
    logic [DUR_W-1:0]     dur_end_c;
    logic                 commit_c;
    logic                 seg_start_c;
    entry_t               commit_entry_c;
    logic                 commit_ok_c;
    logic                 push_c;
    logic                 pop_c;
    logic                 drop_c;
    entry_t               head_c;

    // Event detection and beat tick; a tick coinciding with an event belongs to the ending segment
    always_comb begin
        event_c    = (key_q != key_prev_q);
        counting_c = en && (state_q != S_IDLE);
        tick_c     = counting_c && (presc_q == PRESC_LAST);
        dur_end_c  = (tick_c && (dur_q != DUR_MAX)) ? dur_q + DUR_W'(1) : dur_q;
    end

    // Next-state logic and commit generation
    always_comb begin
        state_d        = state_q;
        cur_pitch_d    = cur_pitch_q;
        commit_c       = 1'b0;
        seg_start_c    = 1'b0;
        commit_entry_c = '0;
        if (!en) begin
            state_d = S_IDLE;
        end else if (event_c) begin
            case (state_q)
                S_IDLE: begin
                    if (key_q != '0) begin
                        state_d     = S_HOLD;
                        cur_pitch_d = key_q;
                        seg_start_c = 1'b1;
                    end
                end
                S_HOLD: begin
                    if (key_q == '0) begin
                        state_d        = S_REST;
                        commit_c       = 1'b1;
                        commit_entry_c = '{pitch: cur_pitch_q, dur: dur_end_c};
                        seg_start_c    = 1'b1;
                    end else if (key_q != cur_pitch_q) begin
                        commit_c       = 1'b1;
                        commit_entry_c = '{pitch: cur_pitch_q, dur: dur_end_c};
                        cur_pitch_d    = key_q;
                        seg_start_c    = 1'b1;
                    end
                end
                S_REST: begin
                    if (key_q != '0) begin
                        state_d        = S_HOLD;
                        commit_c       = 1'b1;
                        commit_entry_c = '{pitch: '0, dur: dur_end_c};
                        cur_pitch_d    = key_q;
                        seg_start_c    = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Prescaler, duration counter and buffer bookkeeping
    always_comb begin
        presc_d    = '0;
        dur_d      = '0;
        if (en && !event_c && counting_c && !tick_c) begin
            presc_d = presc_q + PRESC_W'(1);
        end
        if (en && counting_c && !seg_start_c) begin
            dur_d = dur_end_c;
        end

        commit_ok_c = commit_c && (commit_entry_c.dur != '0);
        pop_c       = rd_en && (count_q != '0);
        // When full, a same-cycle pop frees the slot the commit needs
        push_c      = commit_ok_c && ((count_q != CNT_FULL) || rd_en);
        drop_c      = commit_ok_c && !push_c;

        wr_ptr_d   = push_c ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop_c  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        overflow_d = overflow_q | drop_c;
        count_d    = count_q;
        case ({push_c, pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q       <= '0;
            key_prev_q  <= '0;
            state_q     <= S_IDLE;
            cur_pitch_q <= '0;
            presc_q     <= '0;
            dur_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
        end else begin
            key_q       <= key_code;
            key_prev_q  <= key_q;
            state_q     <= state_d;
            cur_pitch_q <= cur_pitch_d;
            presc_q     <= presc_d;
            dur_q       <= dur_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
        end
    end

    // Entry storage; stale contents are masked by the empty flag on the read side
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= commit_entry_c;
        end
    end

    always_comb begin
        head_c   = mem_q[rd_ptr_q];
        rd_valid = (count_q != '0);
        full     = (count_q == CNT_FULL);
        rd_pitch = rd_valid ? head_c.pitch : '0;
        rd_dur   = rd_valid ? head_c.dur   : '0;
        count    = count_q;
        overflow = overflow_q;
    end

endmodule

// File: doc/note_duration_recorder.md
# note_duration_recorder

Record-side counterpart of the organ's beat-division timing. It watches the debounced key code, measures how long each note and each rest lasts in whole beat ticks, and pushes quantised (pitch, duration) entries into a 16-deep first-word-fall-through buffer. The playback or storage logic drains the buffer through a valid/read handshake. The block sits between the keyboard debouncer and the song memory writer.

## Interface
- TICK_CYCLES, 524288 (2^19): clk cycles per beat tick; must be ≥ 2.
- DEPTH, 16: buffer entries; must be a power of two.
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  recording enable; 0 clears prescaler and FSM, keeps buffer contents.
- key_code  input  5  debounced key; 0 = no key, 1..31 = pitch.
- rd_en  input  1  pop head entry; ignored when rd_valid = 0.
- rd_valid  output  1  buffer non-empty.
- rd_pitch  output  5  head entry pitch; 0 = rest.
- rd_dur  output  3  head entry duration in ticks, 1..7.
- count  output  5  entries held, 0..DEPTH.
- full  output  1  count == DEPTH.
- overflow  output  1  sticky; set when a commit is dropped because the buffer is full; cleared only by reset.

## Operation
- Input stage: key_code is registered into key_q. An event occurs when key_q differs from key_prev, where key_prev is key_q delayed by one cycle.
- Prescaler:
  - Counts 0..TICK_CYCLES-1 while en = 1 and the FSM is in HOLD or REST.
  - Produces a one-cycle tick when it reaches TICK_CYCLES-1, then wraps to 0.
  - Cleared to 0 on every event, so a duration equals floor(cycles since event / TICK_CYCLES).
- Duration counter dur_cnt (3 bits): increments on each tick and saturates at 7. It is cleared when a new HOLD or REST starts.
- FSM states:
  - IDLE: no note recorded yet.
  - HOLD: a key is down; cur_pitch is latched.
  - REST: no key after at least one note.
- FSM transitions on an event:
  - IDLE → HOLD when key_q ≠ 0.
  - HOLD → HOLD when key_q ≠ 0 and differs from cur_pitch. Commit {cur_pitch, dur_cnt}, latch the new pitch.
  - HOLD → REST when key_q = 0. Commit {cur_pitch, dur_cnt}.
  - REST → HOLD when key_q ≠ 0. Commit {0, dur_cnt}.
- Commit rules:
  - A commit with dur_cnt = 0 (note or rest shorter than one tick) is discarded as a glitch. It does not set overflow.
  - A tick in the same cycle as an event is counted into the ending segment before the commit.
- Buffer write and read:
  - A commit writes the buffer when count < DEPTH, or when count == DEPTH and rd_en = 1 in the same cycle.
  - Otherwise the commit is dropped and overflow is set.
  - rd_en with rd_valid = 1 pops the head. A simultaneous write and pop leaves count unchanged.
  - Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- en = 0:
  - FSM returns to IDLE; prescaler and dur_cnt are cleared.
  - key_prev keeps tracking, so no commit is made for the interrupted segment.
  - The buffer can still be read.
- Reset values: FSM IDLE, pointers 0, count 0, rd_valid 0, full 0, overflow 0, rd_pitch 0, rd_dur 0, key_q 0, key_prev 0.

## Timing
- key_code change sampled at edge N → key_q updates at N, event seen and FSM updated at N+1.
- Commit writes the buffer at edge N+1. When the buffer was empty, rd_valid = 1 and rd_pitch/rd_dur are valid after edge N+1 (2-cycle latency).
- rd_pitch/rd_dur always show the head entry combinationally from registered storage. A pop at edge M presents the next entry after M.
- count, full and rd_valid update at the same edge as the write or pop that changes them.
- overflow asserts at the edge of the dropped commit.
- Reset is asynchronous. Asserting it mid-segment discards the segment and the buffer contents immediately.

## Test plan
(All scenarios use TICK_CYCLES = 8.)
- Single note:
  - Stimulus: key 5 for 20 cycles, then 0 for 40 cycles, then key 3.
  - Response: entries {5,2} then {0,5}; rd_valid rises 2 cycles after the release edge.
- Saturation and glitch:
  - Stimulus: key 9 held for 100 cycles, then key 0 for 4 cycles, then key 9 for 16 cycles, then 0.
  - Response: {9,7}, then {9,2}; the 4-cycle rest is not stored.
- Legato and tick collision:
  - Stimulus: key 1 for exactly 16 cycles, then switch directly to key 2, so a tick coincides with the event.
  - Response: {1,2}; HOLD continues for pitch 2 and no rest entry is stored.
- Overflow:
  - Stimulus: 17 valid commits with rd_en = 0.
  - Response: count 16, full 1, overflow 1; the 17th entry is absent.
  - Stimulus: then pop 16 entries.
  - Response: entries come out in order and overflow stays 1.
- Full with simultaneous read:
  - Stimulus: buffer full, and a commit happens in the same cycle as rd_en = 1.
  - Response: count stays 16, overflow stays 0, and the new entry appears last.
- Disable and reset:
  - Stimulus: en dropped mid-hold.
  - Response: no entry; FSM returns to IDLE.
  - Stimulus: rst_n pulsed low for 1 ns mid-operation.
  - Response: all outputs go to 0 immediately, without waiting for a clock edge.
